// File: rtl/regbank16_32bit_wr.sv
// regbank16_32bit_wr
// Write side of a 16-entry register bank. Each entry drives its own
// output (out0..out15) straight into the downstream 16:1 read mux.
// A two-state engine (IDLE / CLEAR) either takes single-cycle writes
// or zeroes the bank one entry per cycle while busy is high.

module regbank16_32bit_wr #(
  parameter int WIDTH     = 32,
  parameter bit ZERO_REG0 = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [3:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_req,
  output logic             wr_ack,
  output logic             busy,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [WIDTH-1:0] out5,
  output logic [WIDTH-1:0] out6,
  output logic [WIDTH-1:0] out7,
  output logic [WIDTH-1:0] out8,
  output logic [WIDTH-1:0] out9,
  output logic [WIDTH-1:0] out10,
  output logic [WIDTH-1:0] out11,
  output logic [WIDTH-1:0] out12,
  output logic [WIDTH-1:0] out13,
  output logic [WIDTH-1:0] out14,
  output logic [WIDTH-1:0] out15
);

  localparam int NUM_ENTRIES = 16;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic             wr_ack_q, wr_ack_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] mem_q [NUM_ENTRIES];
  logic [WIDTH-1:0] mem_d [NUM_ENTRIES];

  // Next-state logic: accept a write, start a clear, or step the clear.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves
    // it unassigned; an unassigned path in always_comb infers a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    mem_d    = mem_q;
    wr_ack_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (clr_req) begin
          // A clear request wins over a same-edge write; the write is lost
          // and no acknowledge is produced.
          state_d = S_CLEAR;
          idx_d   = 4'd0;
        end else if (wr_en) begin
          mem_d[wr_sel] = wr_data;
          wr_ack_d      = 1'b1;
        end
      end

      S_CLEAR: begin
        // One entry per cycle; inputs are ignored until the sweep ends.
        mem_d[idx_q] = '0;
        idx_d        = idx_q + 4'd1;
        if (idx_q == 4'd15) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase

    // Entry 0 reads as constant zero in this configuration; writes to it
    // are still acknowledged above but the data never lands.
    if (ZERO_REG0) begin
      mem_d[0] = '0;
    end

    busy_d = (state_d == S_CLEAR);
  end

  // Control state: FSM, clear index and the registered status outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      wr_ack_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its neighbours, exactly like the hardware.
      state_q  <= state_d;
      idx_q    <= idx_d;
      wr_ack_q <= wr_ack_d;
      busy_q   <= busy_d;
    end
  end

  // Register storage: all 16 entries update together from mem_d.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: this storage is reset because every entry is a visible output
      // that must read zero after reset; a RAM-style array would not be.
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign wr_ack = wr_ack_q;
  assign busy   = busy_q;

  assign out0  = mem_q[0];
  assign out1  = mem_q[1];
  assign out2  = mem_q[2];
  assign out3  = mem_q[3];
  assign out4  = mem_q[4];
  assign out5  = mem_q[5];
  assign out6  = mem_q[6];
  assign out7  = mem_q[7];
  assign out8  = mem_q[8];
  assign out9  = mem_q[9];
  assign out10 = mem_q[10];
  assign out11 = mem_q[11];
  assign out12 = mem_q[12];
  assign out13 = mem_q[13];
  assign out14 = mem_q[14];
  assign out15 = mem_q[15];

endmodule

// File: tb/tb_regbank16_32bit_wr.sv
// Testbench for regbank16_32bit_wr. Two instances share all inputs: one
// with entry 0 hardwired to zero, one without. A behavioural model pushes
// the expected post-edge state into a queue for each driven cycle and the
// entry is popped and compared once the edge has happened.

module tb_regbank16_32bit_wr;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         wr_en = 1'b0;
  logic [3:0]   wr_sel = 4'd0;
  logic [W-1:0] wr_data = '0;
  logic         clr_req = 1'b0;

  logic         ack1, busy1, ack0, busy0;
  logic [W-1:0] o1 [16];
  logic [W-1:0] o0 [16];

  int n_pass  = 0;
  int n_total = 0;

  typedef struct packed {
    logic              ack;
    logic              busy;
    logic [15:0][W-1:0] m1;
    logic [15:0][W-1:0] m0;
  } exp_t;

  exp_t sb_q[$];

  // Reference model state
  logic               m_busy;
  logic [3:0]         m_idx;
  logic               m_ack;
  logic [15:0][W-1:0] m_mem1;
  logic [15:0][W-1:0] m_mem0;

  always #5 clk = ~clk;

  regbank16_32bit_wr #(.WIDTH(W), .ZERO_REG0(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_req(clr_req), .wr_ack(ack1), .busy(busy1),
    .out0(o1[0]), .out1(o1[1]), .out2(o1[2]), .out3(o1[3]),
    .out4(o1[4]), .out5(o1[5]), .out6(o1[6]), .out7(o1[7]),
    .out8(o1[8]), .out9(o1[9]), .out10(o1[10]), .out11(o1[11]),
    .out12(o1[12]), .out13(o1[13]), .out14(o1[14]), .out15(o1[15])
  );

  regbank16_32bit_wr #(.WIDTH(W), .ZERO_REG0(1'b0)) dut_nz (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_sel(wr_sel),
    .wr_data(wr_data), .clr_req(clr_req), .wr_ack(ack0), .busy(busy0),
    .out0(o0[0]), .out1(o0[1]), .out2(o0[2]), .out3(o0[3]),
    .out4(o0[4]), .out5(o0[5]), .out6(o0[6]), .out7(o0[7]),
    .out8(o0[8]), .out9(o0[9]), .out10(o0[10]), .out11(o0[11]),
    .out12(o0[12]), .out13(o0[13]), .out14(o0[14]), .out15(o0[15])
  );

  task automatic model_reset();
    m_busy = 1'b0;
    m_idx  = 4'd0;
    m_ack  = 1'b0;
    m_mem1 = '0;
    m_mem0 = '0;
    sb_q.delete();
  endtask

  // Pop the oldest expectation and compare it against both instances.
  task automatic sb_compare(input string tag);
    exp_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $display("FAIL %s sb_empty: no expectation queued at t=%0t", tag, $time);
      return;
    end
    n_pass++;
    e = sb_q.pop_front();
    n_total++;
    if (ack1 !== e.ack) $display("FAIL %s wr_ack: got %b want %b t=%0t", tag, ack1, e.ack, $time);
    else n_pass++;
    n_total++;
    if (busy1 !== e.busy) $display("FAIL %s busy: got %b want %b t=%0t", tag, busy1, e.busy, $time);
    else n_pass++;
    n_total++;
    if (ack0 !== e.ack) $display("FAIL %s nz_wr_ack: got %b want %b t=%0t", tag, ack0, e.ack, $time);
    else n_pass++;
    n_total++;
    if (busy0 !== e.busy) $display("FAIL %s nz_busy: got %b want %b t=%0t", tag, busy0, e.busy, $time);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (o1[i] !== e.m1[i]) $display("FAIL %s out%0d: got %h want %h t=%0t", tag, i, o1[i], e.m1[i], $time);
      else n_pass++;
      n_total++;
      if (o0[i] !== e.m0[i]) $display("FAIL %s nz_out%0d: got %h want %h t=%0t", tag, i, o0[i], e.m0[i], $time);
      else n_pass++;
    end
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic drive(input logic en, input logic [3:0] sel,
                       input logic [W-1:0] data, input logic clr, input string tag);
    exp_t e;
    @(negedge clk);
    wr_en   = en;
    wr_sel  = sel;
    wr_data = data;
    clr_req = clr;
    if (!m_busy) begin
      if (clr) begin
        m_busy = 1'b1;
        m_idx  = 4'd0;
        m_ack  = 1'b0;
      end else if (en) begin
        if (sel != 4'd0) m_mem1[sel] = data;
        m_mem0[sel] = data;
        m_ack = 1'b1;
      end else begin
        m_ack = 1'b0;
      end
    end else begin
      m_mem1[m_idx] = '0;
      m_mem0[m_idx] = '0;
      m_ack = 1'b0;
      if (m_idx == 4'd15) m_busy = 1'b0;
      m_idx = m_idx + 4'd1;
    end
    e.ack  = m_ack;
    e.busy = m_busy;
    e.m1   = m_mem1;
    e.m0   = m_mem0;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    sb_compare(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) drive(1'b0, 4'd0, '0, 1'b0, tag);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    model_reset();
    #3;
    n_total++;
    if (ack1 !== 1'b0 || busy1 !== 1'b0) $display("FAIL reset_ctrl: ack=%b busy=%b want 0 0", ack1, busy1);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (o1[i] !== '0 || o0[i] !== '0) $display("FAIL reset_out%0d: got %h/%h want 0", i, o1[i], o0[i]);
      else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_fill();
    int acks = 0;
    for (int k = 1; k <= 15; k++) begin
      drive(1'b1, 4'(k), W'(k * 3 + 1), 1'b0, "fill");
      if (ack1 === 1'b1) acks++;
    end
    n_total++;
    if (acks != 15) $display("FAIL fill_ack_run: got %0d acked cycles want 15", acks);
    else n_pass++;
    n_total++;
    if (o1[1] !== 32'd4 || o1[5] !== 32'd16 || o1[15] !== 32'd46 || o1[0] !== 32'd0)
      $display("FAIL fill_values: out1=%0d out5=%0d out15=%0d out0=%0d want 4 16 46 0",
               o1[1], o1[5], o1[15], o1[0]);
    else n_pass++;
    idle(1, "fill_idle");
    n_total++;
    if (ack1 !== 1'b0) $display("FAIL fill_ack_drop: got %b want 0", ack1);
    else n_pass++;
  endtask

  task automatic test_zero_reg0();
    drive(1'b1, 4'd0, 32'hDEADBEEF, 1'b0, "zreg");
    n_total++;
    if (o1[0] !== 32'd0 || ack1 !== 1'b1)
      $display("FAIL zreg_discard: out0=%h ack=%b want 00000000 1", o1[0], ack1);
    else n_pass++;
    n_total++;
    if (o0[0] !== 32'hDEADBEEF || ack0 !== 1'b1)
      $display("FAIL zreg_off_write: out0=%h ack=%b want deadbeef 1", o0[0], ack0);
    else n_pass++;
    idle(1, "zreg_idle");
    n_total++;
    if (ack1 !== 1'b0) $display("FAIL zreg_ack_pulse: got %b want 0", ack1);
    else n_pass++;
  endtask

  task automatic test_clear();
    int busy_cycles = 0;
    for (int k = 0; k < 16; k++) drive(1'b1, 4'(k), 32'hFFFFFFFF, 1'b0, "clr_fill");
    idle(1, "clr_pre");
    drive(1'b0, 4'd0, '0, 1'b1, "clr_start");
    if (busy1 === 1'b1) busy_cycles++;
    for (int c = 1; c <= 20; c++) begin
      drive(1'b0, 4'd0, '0, 1'b0, "clr_run");
      if (busy1 === 1'b1) busy_cycles++;
      if (c == 8) begin
        for (int i = 0; i < 16; i++) begin
          n_total++;
          if (i < 8 && (o1[i] !== '0 || o0[i] !== '0))
            $display("FAIL clr_half_lo out%0d: got %h/%h want 0", i, o1[i], o0[i]);
          else if (i >= 8 && (o1[i] !== 32'hFFFFFFFF || o0[i] !== 32'hFFFFFFFF))
            $display("FAIL clr_half_hi out%0d: got %h/%h want ffffffff", i, o1[i], o0[i]);
          else n_pass++;
        end
      end
    end
    n_total++;
    if (busy_cycles != 16) $display("FAIL clr_busy_len: got %0d want 16", busy_cycles);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (o1[i] !== '0 || o0[i] !== '0) $display("FAIL clr_done out%0d: got %h/%h want 0", i, o1[i], o0[i]);
      else n_pass++;
    end
  endtask

  task automatic test_clr_wr_same_edge();
    drive(1'b1, 4'd4, 32'd11, 1'b0, "same_pre");
    drive(1'b1, 4'd4, 32'd99, 1'b1, "same_edge");
    n_total++;
    if (ack1 !== 1'b0 || busy1 !== 1'b1 || o1[4] !== 32'd11)
      $display("FAIL same_edge: ack=%b busy=%b out4=%0d want 0 1 11", ack1, busy1, o1[4]);
    else n_pass++;
    for (int c = 0; c < 16; c++) begin
      drive(1'b0, 4'd0, '0, 1'b0, "same_run");
      n_total++;
      if (o1[4] === 32'd99) $display("FAIL same_no99: got %0d want not 99", o1[4]);
      else n_pass++;
    end
    n_total++;
    if (busy1 !== 1'b0 || o1[4] !== 32'd0) $display("FAIL same_end: busy=%b out4=%0d want 0 0", busy1, o1[4]);
    else n_pass++;
  endtask

  task automatic test_wr_during_clear();
    drive(1'b1, 4'd12, 32'd55, 1'b0, "dur_pre");
    drive(1'b0, 4'd0, '0, 1'b1, "dur_start");
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, 4'd12, 32'd7, 1'b0, "dur_wr");
      n_total++;
      if (ack1 !== 1'b0 || o1[12] === 32'd7) $display("FAIL dur_ignored: ack=%b out12=%0d want 0 !7", ack1, o1[12]);
      else n_pass++;
    end
    drive(1'b0, 4'd0, '0, 1'b1, "dur_clr_again");
    idle(11, "dur_run");
    n_total++;
    if (busy1 !== 1'b1) $display("FAIL dur_busy_hold: got %b want 1", busy1);
    else n_pass++;
    idle(1, "dur_last");
    n_total++;
    if (busy1 !== 1'b0 || o1[12] !== 32'd0) $display("FAIL dur_end: busy=%b out12=%0d want 0 0", busy1, o1[12]);
    else n_pass++;
  endtask

  task automatic test_reset_mid_clear();
    drive(1'b1, 4'd10, 32'd123, 1'b0, "rst_pre");
    drive(1'b0, 4'd0, '0, 1'b1, "rst_start");
    idle(5, "rst_run");
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    n_total++;
    if (busy1 !== 1'b0 || ack1 !== 1'b0 || busy0 !== 1'b0)
      $display("FAIL rst_async_ctrl: busy=%b ack=%b want 0 0", busy1, ack1);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      n_total++;
      if (o1[i] !== '0 || o0[i] !== '0) $display("FAIL rst_async out%0d: got %h/%h want 0", i, o1[i], o0[i]);
      else n_pass++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 4'd3, 32'd3, 1'b0, "rst_after");
    n_total++;
    if (o1[3] !== 32'd3 || ack1 !== 1'b1) $display("FAIL rst_after_wr: out3=%0d ack=%b want 3 1", o1[3], ack1);
    else n_pass++;
    idle(2, "rst_tail");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_zero_reg0();
    test_clear();
    test_clr_wr_same_edge();
    test_wr_during_clear();
    test_reset_mid_clear();
    n_total++;
    if (sb_q.size() != 0) $display("FAIL sb_leftover: %0d entries never compared", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
